// File: rtl/pll_lock_rst_mgr.sv
// PLL lock qualifier and downstream reset sequencer: pulses the PLL reset, waits for a
// stable synchronized lock, holds rst_out_n released while locked, retries or fails on timeout.
module pll_lock_rst_mgr #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1000,
  parameter int MAX_RETRY        = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       rst_out_n,
  output logic       locked_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);
  localparam int RST_W = $clog2(RST_PULSE_CYC + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYC + 1);

  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_PULSE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE_CHK,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync_q;
  logic             lock_s;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [STB_W-1:0] stb_cnt, stb_cnt_nxt;
  logic [3:0]       retry_cnt_nxt;
  logic [7:0]       loss_cnt_nxt;
  logic             pll_rst_nxt, rst_out_n_nxt, locked_ok_nxt, fail_nxt;

  // pll_lock is asynchronous to sys_clk; two flops before any decision uses it
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sync_q <= '0;
    else            sync_q <= {sync_q[0], pll_lock};
  end

  assign lock_s = sync_q[1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_RESET_PLL;
      rst_cnt       <= '0;
      to_cnt        <= '0;
      stb_cnt       <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      rst_out_n     <= 1'b0;
      locked_ok     <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_nxt;
      rst_cnt       <= rst_cnt_nxt;
      to_cnt        <= to_cnt_nxt;
      stb_cnt       <= stb_cnt_nxt;
      retry_cnt     <= retry_cnt_nxt;
      lock_loss_cnt <= loss_cnt_nxt;
      pll_rst       <= pll_rst_nxt;
      rst_out_n     <= rst_out_n_nxt;
      locked_ok     <= locked_ok_nxt;
      fail          <= fail_nxt;
    end
  end

  // Counters are cleared whenever the state is left, so every entry starts from zero
  always_comb begin
    state_nxt     = state;
    rst_cnt_nxt   = '0;
    to_cnt_nxt    = '0;
    stb_cnt_nxt   = '0;
    retry_cnt_nxt = retry_cnt;
    loss_cnt_nxt  = lock_loss_cnt;
    case (state)
      ST_RESET_PLL: begin
        if (rst_cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
        else                     rst_cnt_nxt = rst_cnt + 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          // The cycle that observed lock already counts toward the stability window
          if (LOCK_STABLE_CYC == 1) begin
            state_nxt     = ST_RUN;
            retry_cnt_nxt = '0;
          end else begin
            state_nxt   = ST_STABLE_CHK;
            stb_cnt_nxt = STB_W'(1);
          end
        end else if (to_cnt == TO_LAST) begin
          retry_cnt_nxt = retry_cnt + 4'd1;
          state_nxt     = (retry_cnt_nxt == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      ST_STABLE_CHK: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (stb_cnt == STB_LAST) begin
          state_nxt     = ST_RUN;
          retry_cnt_nxt = '0;
        end else begin
          stb_cnt_nxt = stb_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_RESET_PLL;
          if (lock_loss_cnt != 8'hFF) loss_cnt_nxt = lock_loss_cnt + 8'd1;
        end
      end
      ST_FAIL: begin
        if (retry_req) begin
          state_nxt     = ST_RESET_PLL;
          retry_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_RESET_PLL;
    endcase
  end

  // Outputs decode the next state so they register on the same edge as the state
  always_comb begin
    pll_rst_nxt   = (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
    rst_out_n_nxt = (state_nxt == ST_RUN);
    locked_ok_nxt = (state_nxt == ST_RUN);
    fail_nxt      = (state_nxt == ST_FAIL);
  end

endmodule

// File: tb/tb_pll_lock_rst_mgr.sv
// Directed bench for pll_lock_rst_mgr with short timing parameters.
module tb_pll_lock_rst_mgr;
  localparam int P = 4;
  localparam int T = 20;
  localparam int S = 8;
  localparam int R = 2;
  localparam int BOUND = 200;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_rst, rst_out_n, locked_ok, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  int         total = 0;
  int         bad = 0;

  pll_lock_rst_mgr #(
    .RST_PULSE_CYC(P), .LOCK_TIMEOUT_CYC(T), .LOCK_STABLE_CYC(S), .MAX_RETRY(R)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock), .retry_req(retry_req),
    .pll_rst(pll_rst), .rst_out_n(rst_out_n), .locked_ok(locked_ok), .fail(fail),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    pll_lock  = 1'b0;
    retry_req = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_pll_rst(input logic val, output int n);
    n = 0;
    while (pll_rst !== val && n < BOUND) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic wait_rst_out(input logic val, output int n);
    n = 0;
    while (rst_out_n !== val && n < BOUND) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  // Runs from RESET_PLL with pll_lock low through to RUN
  task automatic lock_up(input string tag);
    int n;
    wait_pll_rst(1'b0, n);
    total++;
    if (n !== P) begin bad++; $display("FAIL %s pll_rst_len: got %0d want %0d", tag, n, P); end
    tick(5);
    pll_lock = 1'b1;
    tick(1);
    total++;
    if (dut.lock_s !== 1'b0) begin bad++; $display("FAIL %s lock_s_1: got %b want 0", tag, dut.lock_s); end
    tick(1);
    total++;
    if (dut.lock_s !== 1'b1) begin bad++; $display("FAIL %s lock_s_2: got %b want 1", tag, dut.lock_s); end
    wait_rst_out(1'b1, n);
    total++;
    if (n !== S) begin bad++; $display("FAIL %s rst_out_delay: got %0d want %0d", tag, n, S); end
    total++;
    if ({locked_ok, pll_rst, retry_cnt} !== {1'b1, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL %s run_outputs: got ok=%b rst=%b rc=%0d want ok=1 rst=0 rc=0",
               tag, locked_ok, pll_rst, retry_cnt);
    end
  endtask

  task automatic test_reset();
    tick(2);
    total++;
    if ({pll_rst, rst_out_n, locked_ok, fail, retry_cnt, lock_loss_cnt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_values: got rst=%b out=%b ok=%b fail=%b rc=%0d llc=%0d want 1 0 0 0 0 0",
               pll_rst, rst_out_n, locked_ok, fail, retry_cnt, lock_loss_cnt);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    lock_up("lock");
  endtask

  task automatic test_retry_run();
    retry_req = 1'b1;
    tick(1);
    retry_req = 1'b0;
    tick(3);
    total++;
    if ({rst_out_n, locked_ok, pll_rst, fail} !== 4'b1100) begin
      bad++;
      $display("FAIL retry_in_run: got %b want 1100", {rst_out_n, locked_ok, pll_rst, fail});
    end
  endtask

  task automatic test_loss();
    int n;
    pll_lock = 1'b0;
    tick(2);
    total++;
    if (rst_out_n !== 1'b1) begin bad++; $display("FAIL loss_early: got %b want 1", rst_out_n); end
    tick(1);
    total++;
    if ({rst_out_n, pll_rst, locked_ok, lock_loss_cnt} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL loss_edge: got out=%b rst=%b ok=%b llc=%0d want 0 1 0 1",
               rst_out_n, pll_rst, locked_ok, lock_loss_cnt);
    end
    lock_up("relock");
    for (int i = 0; i < 254; i++) begin
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      wait_rst_out(1'b0, n);
      if (n >= BOUND) break;
      wait_rst_out(1'b1, n);
      if (n >= BOUND) break;
    end
    total++;
    if (lock_loss_cnt !== 8'd255) begin bad++; $display("FAIL loss_255: got %0d want 255", lock_loss_cnt); end
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_rst_out(1'b0, n);
    total++;
    if (lock_loss_cnt !== 8'd255 || n >= BOUND) begin
      bad++;
      $display("FAIL loss_sat: got %0d want 255 (wait %0d)", lock_loss_cnt, n);
    end
  endtask

  task automatic test_glitch();
    int n;
    apply_reset();
    wait_pll_rst(1'b0, n);
    pll_lock = 1'b1;
    tick(2);
    total++;
    if (dut.lock_s !== 1'b1) begin bad++; $display("FAIL glitch_lock_s: got %b want 1", dut.lock_s); end
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    total++;
    if ({dut.lock_s, rst_out_n} !== 2'b00) begin
      bad++;
      $display("FAIL glitch_dip: got lock_s=%b out=%b want 0 0", dut.lock_s, rst_out_n);
    end
    tick(1);
    total++;
    if ({dut.lock_s, rst_out_n} !== 2'b10) begin
      bad++;
      $display("FAIL glitch_no_run: got lock_s=%b out=%b want 1 0", dut.lock_s, rst_out_n);
    end
    wait_rst_out(1'b1, n);
    total++;
    if (n !== S) begin bad++; $display("FAIL glitch_restart: got %0d want %0d", n, S); end
    total++;
    if ({retry_cnt, pll_rst} !== {4'd0, 1'b0}) begin
      bad++;
      $display("FAIL glitch_retry: got rc=%0d rst=%b want 0 0", retry_cnt, pll_rst);
    end
  endtask

  task automatic test_fail();
    int n;
    apply_reset();
    wait_pll_rst(1'b0, n);
    total++;
    if (n !== P) begin bad++; $display("FAIL fail_pulse1: got %0d want %0d", n, P); end
    wait_pll_rst(1'b1, n);
    total++;
    if (n !== T) begin bad++; $display("FAIL fail_wait1: got %0d want %0d", n, T); end
    total++;
    if ({retry_cnt, fail} !== {4'd1, 1'b0}) begin
      bad++;
      $display("FAIL fail_retry1: got rc=%0d fail=%b want 1 0", retry_cnt, fail);
    end
    wait_pll_rst(1'b0, n);
    total++;
    if (n !== P) begin bad++; $display("FAIL fail_pulse2: got %0d want %0d", n, P); end
    wait_pll_rst(1'b1, n);
    total++;
    if (n !== T) begin bad++; $display("FAIL fail_wait2: got %0d want %0d", n, T); end
    total++;
    if ({fail, retry_cnt, rst_out_n} !== {1'b1, 4'd2, 1'b0}) begin
      bad++;
      $display("FAIL fail_enter: got fail=%b rc=%0d out=%b want 1 2 0", fail, retry_cnt, rst_out_n);
    end
    tick(5);
    total++;
    if ({pll_rst, fail} !== 2'b11) begin
      bad++;
      $display("FAIL fail_hold: got rst=%b fail=%b want 1 1", pll_rst, fail);
    end
    retry_req = 1'b1;
    tick(1);
    retry_req = 1'b0;
    total++;
    if ({fail, retry_cnt, pll_rst} !== {1'b0, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL fail_retry_req: got fail=%b rc=%0d rst=%b want 0 0 1", fail, retry_cnt, pll_rst);
    end
    wait_pll_rst(1'b0, n);
    total++;
    if (n !== P) begin bad++; $display("FAIL fail_restart_pulse: got %0d want %0d", n, P); end
  endtask

  // Continues from the WAIT_LOCK entry left by test_fail
  task automatic test_retry_wait();
    int n;
    tick(3);
    retry_req = 1'b1;
    tick(1);
    retry_req = 1'b0;
    wait_pll_rst(1'b1, n);
    total++;
    if ({n, retry_cnt} !== {32'd16, 4'd1}) begin
      bad++;
      $display("FAIL retry_in_wait: got wait=%0d rc=%0d want 16 1", n, retry_cnt);
    end
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    wait_pll_rst(1'b0, n);
    wait_pll_rst(1'b1, n);
    wait_pll_rst(1'b0, n);
    pll_lock = 1'b1;
    tick(4);
    total++;
    if ({retry_cnt, rst_out_n} !== {4'd1, 1'b0}) begin
      bad++;
      $display("FAIL arst_pre_stable: got rc=%0d out=%b want 1 0", retry_cnt, rst_out_n);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    total++;
    if ({pll_rst, rst_out_n, locked_ok, fail, retry_cnt, dut.lock_s} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL arst_stable: got rst=%b out=%b ok=%b fail=%b rc=%0d lock_s=%b want 1 0 0 0 0 0",
               pll_rst, rst_out_n, locked_ok, fail, retry_cnt, dut.lock_s);
    end
    apply_reset();
    lock_up("arst_lock1");
    pll_lock = 1'b0;
    tick(3);
    lock_up("arst_lock2");
    total++;
    if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL arst_pre_run: got %0d want 1", lock_loss_cnt); end
    #2 sys_rst_n = 1'b0;
    #1;
    total++;
    if ({pll_rst, rst_out_n, locked_ok, fail, retry_cnt, lock_loss_cnt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      bad++;
      $display("FAIL arst_run: got rst=%b out=%b ok=%b fail=%b rc=%0d llc=%0d want 1 0 0 0 0 0",
               pll_rst, rst_out_n, locked_ok, fail, retry_cnt, lock_loss_cnt);
    end
    tick(1);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_retry_run();
    test_loss();
    test_glitch();
    test_fail();
    test_retry_wait();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
